// File: rtl/vic_pkg.sv
// Shared definitions for the vectored interrupt controller.
// Holds the handshake state enum, the vector word width and the default spurious vector.
package vic_pkg;

  localparam int unsigned VEC_W = 16;

  localparam logic [VEC_W-1:0] SPUR_VEC_DEF = 16'o000000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    ACK      = 2'd2,
    WAIT_LOW = 2'd3
  } vic_state_e;

endpackage

// File: rtl/vec_irq_ctrl_if.sv
// Bus bundle between peripherals/CPU and the vectored interrupt controller.
//   irq_req  [N]        level requests, bit 0 highest priority
//   irq_mask [N]        per-source enable
//   irq_vec  [16*N]     packed per-source vectors
//   irq_ack  [N]        one-cycle acknowledge to the winning source
//   virq, istb, ivec, iack   CPU vector-fetch handshake
// slave: controller view; master: peripheral/CPU (driver) view.
interface vec_irq_ctrl_if
  import vic_pkg::*;
#(
  parameter int unsigned N = 8
) ();

  logic [N-1:0]       irq_req;
  logic [N-1:0]       irq_mask;
  logic [VEC_W*N-1:0] irq_vec;
  logic [N-1:0]       irq_ack;
  logic               virq;
  logic               istb;
  logic [VEC_W-1:0]   ivec;
  logic               iack;

  modport slave (
    input  irq_req, irq_mask, irq_vec, istb,
    output irq_ack, virq, ivec, iack
  );

  modport master (
    output irq_req, irq_mask, irq_vec, istb,
    input  irq_ack, virq, ivec, iack
  );

endinterface

// File: rtl/vic_prio_enc.sv
// Purely combinational fixed-priority encoder; bit 0 wins.
//   i_req     [N]   request vector
//   o_idx_c   [IW]  index of the lowest set bit (0 when none set)
//   o_any_c         at least one bit set
module vic_prio_enc #(
  parameter  int unsigned N  = 8,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  output logic [IW-1:0] o_idx_c,
  output logic          o_any_c
);

  // Scan from the top so the lowest set index is the last assignment.
  always_comb begin
    o_idx_c = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx_c = IW'(i);
    end
  end

  assign o_any_c = |i_req;

endmodule

// File: rtl/vec_irq_ctrl.sv
// Vectored interrupt controller in front of the 1801VM1 virq/istb/ivec/iack inputs.
//   clk_p  system clock (rising edge)
//   rst_n  asynchronous active-low reset
//   bus    vec_irq_ctrl_if.slave: peripheral requests/masks/vectors/acks and CPU handshake
// All outputs are registered; each register is loaded with the value belonging to
// the state being entered, so outputs track the state with no input-to-output path.
module vec_irq_ctrl
  import vic_pkg::*;
#(
  parameter int unsigned      N        = 8,
  parameter logic [VEC_W-1:0] SPUR_VEC = SPUR_VEC_DEF
) (
  input  logic            clk_p,
  input  logic            rst_n,
  vec_irq_ctrl_if.slave   bus
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  vic_state_e       r_state, w_state_nxt;
  logic             r_virq, w_virq_nxt;
  logic             r_iack, w_iack_nxt;
  logic [VEC_W-1:0] r_ivec, w_ivec_nxt;
  logic [N-1:0]     r_irq_ack, w_irq_ack_nxt;
  logic [IW-1:0]    r_win, w_win_nxt;

  logic [N-1:0]     w_eff;
  logic [IW-1:0]    w_idx;
  logic             w_any;
  logic [VEC_W-1:0] w_sel_vec;

  assign w_eff = bus.irq_req & bus.irq_mask;

  vic_prio_enc #(.N(N)) u_prio (
    .i_req   (w_eff),
    .o_idx_c (w_idx),
    .o_any_c (w_any)
  );

  // Vector of the current arbitration winner.
  always_comb begin
    w_sel_vec = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (w_idx == IW'(i)) w_sel_vec = bus.irq_vec[i*VEC_W +: VEC_W];
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    w_state_nxt   = r_state;
    w_virq_nxt    = r_virq;
    w_iack_nxt    = r_iack;
    w_ivec_nxt    = r_ivec;
    w_irq_ack_nxt = '0;
    w_win_nxt     = r_win;
    case (r_state)
      IDLE: begin
        if (bus.istb) begin
          // Fetch without a raised virq is answered spuriously.
          w_state_nxt = ACK;
          w_virq_nxt  = 1'b0;
          w_iack_nxt  = 1'b1;
          w_ivec_nxt  = SPUR_VEC;
        end else if (w_any) begin
          w_state_nxt = ARMED;
          w_virq_nxt  = 1'b1;
        end
      end
      ARMED: begin
        // istb wins over withdrawal; eff is re-evaluated in the istb cycle.
        if (bus.istb) begin
          w_state_nxt = ACK;
          w_virq_nxt  = 1'b0;
          w_iack_nxt  = 1'b1;
          if (w_any) begin
            w_win_nxt     = w_idx;
            w_ivec_nxt    = w_sel_vec;
            w_irq_ack_nxt = N'(1) << w_idx;
          end else begin
            w_ivec_nxt = SPUR_VEC;
          end
        end else if (!w_any) begin
          w_state_nxt = IDLE;
          w_virq_nxt  = 1'b0;
        end
      end
      ACK: begin
        w_state_nxt = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!bus.istb) begin
          w_state_nxt = IDLE;
          w_iack_nxt  = 1'b0;
          w_ivec_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_virq_nxt  = 1'b0;
        w_iack_nxt  = 1'b0;
        w_ivec_nxt  = '0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Output and winner registers.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      r_virq    <= 1'b0;
      r_iack    <= 1'b0;
      r_ivec    <= '0;
      r_irq_ack <= '0;
      r_win     <= '0;
    end else begin
      r_virq    <= w_virq_nxt;
      r_iack    <= w_iack_nxt;
      r_ivec    <= w_ivec_nxt;
      r_irq_ack <= w_irq_ack_nxt;
      r_win     <= w_win_nxt;
    end
  end

  assign bus.virq    = r_virq;
  assign bus.iack    = r_iack;
  assign bus.ivec    = r_ivec;
  assign bus.irq_ack = r_irq_ack;

endmodule

// File: tb/tb_vec_irq_ctrl.sv
// Self-checking bench for vec_irq_ctrl: transaction-level reference model compared
// every falling edge, plus directed literal expectations for each scenario.
module tb_vec_irq_ctrl;
  import vic_pkg::*;

  localparam int unsigned N = 8;

  logic clk_p = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk_p = ~clk_p;

  vec_irq_ctrl_if #(.N(N)) bus ();

  vec_irq_ctrl #(.N(N), .SPUR_VEC(16'o000000)) dut (
    .clk_p (clk_p),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] vecs [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pack_vecs();
    for (int i = 0; i < int'(N); i++) bus.irq_vec[i*16 +: 16] = vecs[i];
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_p);
    #2;
  endtask

  // ---------------- reference model ----------------
  // virq mirrors "some enabled request" one cycle late while no fetch is in progress.
  // A fetch seen while virq is up goes to the lowest enabled source (or spurious);
  // a fetch while virq is down is spurious. The fetch answer lasts one acknowledge
  // cycle plus as long as istb stays high afterwards.
  bit          m_busy = 1'b0;
  bit          m_virq = 1'b0;
  int          m_age  = 0;
  int          m_win  = -1;
  logic [15:0] m_vec  = '0;

  function automatic int lowest(input logic [N-1:0] e);
    for (int i = 0; i < int'(N); i++) if (e[i]) return i;
    return -1;
  endfunction

  function automatic logic [15:0] vec_of(input int w);
    if (w < 0) return 16'o000000;
    return bus.irq_vec[w*16 +: 16];
  endfunction

  function automatic logic [N-1:0] exp_ack();
    if (m_busy && m_age == 0 && m_win >= 0) return N'(1) << m_win;
    return '0;
  endfunction

  always @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_virq <= 1'b0;
      m_age  <= 0;
      m_win  <= -1;
      m_vec  <= '0;
    end else if (m_busy) begin
      if (m_age == 0)    m_age  <= 1;
      else if (!bus.istb) m_busy <= 1'b0;
      m_virq <= 1'b0;
    end else if (bus.istb) begin
      m_win  <= m_virq ? lowest(bus.irq_req & bus.irq_mask) : -1;
      m_vec  <= vec_of(m_virq ? lowest(bus.irq_req & bus.irq_mask) : -1);
      m_busy <= 1'b1;
      m_age  <= 0;
      m_virq <= 1'b0;
    end else begin
      m_virq <= |(bus.irq_req & bus.irq_mask);
    end
  end

  always @(negedge clk_p) begin
    chk("model_virq",    32'(bus.virq),    32'(m_virq));
    chk("model_iack",    32'(bus.iack),    32'(m_busy));
    chk("model_ivec",    32'(bus.ivec),    32'(m_busy ? m_vec : 16'h0));
    chk("model_irq_ack", 32'(bus.irq_ack), 32'(exp_ack()));
  end

  // ---------------- directed stimulus ----------------
  initial begin
    bus.irq_req  = 8'h04;
    bus.irq_mask = 8'hFF;
    bus.istb     = 1'b0;
    for (int i = 0; i < int'(N); i++) vecs[i] = 16'o000300 + 16'(i * 4);
    vecs[1] = 16'o000064;
    vecs[2] = 16'o000060;
    vecs[3] = 16'o000100;
    vecs[5] = 16'o000200;
    pack_vecs();

    // Reset with a request pending.
    #1 rst_n = 1'b0;
    tick(3);
    chk("rst_virq", 32'(bus.virq), 32'd0);
    chk("rst_iack", 32'(bus.iack), 32'd0);
    chk("rst_ivec", 32'(bus.ivec), 32'd0);
    rst_n = 1'b1;
    tick(1);
    chk("rst_rel_virq", 32'(bus.virq), 32'd1);

    // Single source, istb held three cycles, vector changed after sampling.
    bus.istb = 1'b1;
    tick(1);
    chk("single_iack",    32'(bus.iack),    32'd1);
    chk("single_ivec",    32'(bus.ivec),    32'(16'o000060));
    chk("single_irq_ack", 32'(bus.irq_ack), 32'h04);
    chk("single_virq",    32'(bus.virq),    32'd0);
    vecs[2] = 16'o000777;
    pack_vecs();
    tick(1);
    chk("single_ack_once", 32'(bus.irq_ack), 32'h00);
    chk("single_ivec_hold", 32'(bus.ivec),   32'(16'o000060));
    chk("single_iack_hold", 32'(bus.iack),   32'd1);
    tick(1);
    bus.istb    = 1'b0;
    bus.irq_req = 8'h00;
    tick(1);
    chk("single_iack_drop", 32'(bus.iack), 32'd0);
    chk("single_ivec_drop", 32'(bus.ivec), 32'd0);
    vecs[2] = 16'o000060;
    pack_vecs();

    // Priority between sources 1 and 3.
    bus.irq_req = 8'h0A;
    tick(1);
    chk("prio_virq", 32'(bus.virq), 32'd1);
    bus.istb = 1'b1;
    tick(1);
    chk("prio1_ivec",    32'(bus.ivec),    32'(16'o000064));
    chk("prio1_irq_ack", 32'(bus.irq_ack), 32'h02);
    bus.istb    = 1'b0;
    bus.irq_req = 8'h08;
    tick(3);
    chk("prio_rearm_virq", 32'(bus.virq), 32'd1);
    bus.istb = 1'b1;
    tick(1);
    chk("prio3_ivec",    32'(bus.ivec),    32'(16'o000100));
    chk("prio3_irq_ack", 32'(bus.irq_ack), 32'h08);
    bus.istb    = 1'b0;
    bus.irq_req = 8'h00;
    tick(2);
    chk("prio_idle_iack", 32'(bus.iack), 32'd0);

    // Mask removed in the istb cycle -> spurious.
    bus.irq_req = 8'h20;
    tick(1);
    chk("mask_virq", 32'(bus.virq), 32'd1);
    bus.irq_mask = 8'hDF;
    bus.istb     = 1'b1;
    tick(1);
    chk("mask_iack",    32'(bus.iack),    32'd1);
    chk("mask_ivec",    32'(bus.ivec),    32'(16'o000000));
    chk("mask_irq_ack", 32'(bus.irq_ack), 32'h00);
    bus.istb     = 1'b0;
    bus.irq_req  = 8'h00;
    bus.irq_mask = 8'hFF;
    tick(3);

    // Spurious fetch from IDLE.
    bus.istb = 1'b1;
    tick(1);
    chk("spur_iack",    32'(bus.iack),    32'd1);
    chk("spur_ivec",    32'(bus.ivec),    32'(16'o000000));
    chk("spur_irq_ack", 32'(bus.irq_ack), 32'h00);
    bus.istb = 1'b0;
    tick(1);
    chk("spur_wait_iack", 32'(bus.iack), 32'd1);
    tick(1);
    chk("spur_idle_iack", 32'(bus.iack), 32'd0);
    chk("spur_idle_virq", 32'(bus.virq), 32'd0);

    // Extremes: all sources (index 0 wins), then only the lowest-priority source.
    bus.irq_req = 8'hFF;
    tick(1);
    bus.istb = 1'b1;
    tick(1);
    chk("all_ivec",    32'(bus.ivec),    32'(16'o000300));
    chk("all_irq_ack", 32'(bus.irq_ack), 32'h01);
    bus.istb    = 1'b0;
    bus.irq_req = 8'h80;
    tick(3);
    bus.istb = 1'b1;
    tick(1);
    chk("src7_ivec",    32'(bus.ivec),    32'(16'o000334));
    chk("src7_irq_ack", 32'(bus.irq_ack), 32'h80);
    bus.istb    = 1'b0;
    bus.irq_req = 8'h00;
    tick(3);

    // Reset in the acknowledge cycle.
    bus.irq_req = 8'h04;
    tick(1);
    bus.istb = 1'b1;
    tick(1);
    chk("midack_iack_pre", 32'(bus.iack), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midack_iack",    32'(bus.iack),    32'd0);
    chk("midack_ivec",    32'(bus.ivec),    32'd0);
    chk("midack_irq_ack", 32'(bus.irq_ack), 32'h00);
    bus.istb = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("midack_rearm_virq", 32'(bus.virq),    32'd1);
    chk("midack_no_ack",     32'(bus.irq_ack), 32'h00);
    bus.istb = 1'b1;
    tick(1);
    chk("midack_fetch_ivec", 32'(bus.ivec), 32'(16'o000060));
    bus.istb    = 1'b0;
    bus.irq_req = 8'h00;
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/vec_irq_ctrl.md
Name: vec_irq_ctrl

Overview:
Vectored interrupt controller sitting directly upstream of the processor module's virq/ivec/istb/iack inputs.
- Collects level requests from up to N peripherals (serial ports, disk controllers, etc.) and applies per-source masking.
- Raises a single virq to the 1801VM1 core.
- On the CPU's vector-fetch strobe, latches the winning source and answers with its 16-bit vector plus iack.
- Returns a one-cycle acknowledge pulse to the winning peripheral so it can drop its request.

Parameters:
N, 8, number of request sources (1..16).
SPUR_VEC, 16'o000000, vector returned when istb arrives with no enabled request pending.

Ports:
clk_p  in  1  system clock, rising edge (same clock as the processor module).
rst_n  in  1  asynchronous active-low reset.
irq_req  in  N  level requests from peripherals; bit 0 is highest priority.
irq_mask  in  N  per-source enable, 1 = enabled.
irq_vec  in  16*N  packed vectors; source i occupies bits [16*i+15:16*i].
irq_ack  out  N  one-cycle acknowledge pulse to the selected source.
virq  out  1  vectored interrupt request to the CPU.
istb  in  1  vector-fetch strobe from the CPU.
ivec  out  16  vector bus to the CPU.
iack  out  1  vector-valid acknowledge to the CPU.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, virq=0, iack=0, ivec=0, irq_ack=0, latched index=0.
- Effective request: eff = irq_req & irq_mask.
- Output registering: all outputs are registered, with no combinational path from inputs to outputs.
- States: IDLE, ARMED, ACK, WAIT_LOW.
- IDLE:
  - If istb=1, go to ACK with the spurious flag set.
  - Otherwise, if |eff, go to ARMED; virq=1 from the next cycle (1-cycle request latency).
- ARMED:
  - virq stays 1.
  - If eff becomes 0 before istb, return to IDLE and virq drops the next cycle.
  - If istb=1, latch win = lowest set index of eff in that same cycle and go to ACK.
  - If eff=0 in the istb cycle, set the spurious flag instead of latching a source.
  - istb takes precedence over the withdrawal check.
- ACK (exactly one cycle):
  - virq=0 and iack=1.
  - ivec = irq_vec[win], or SPUR_VEC if spurious.
  - irq_ack[win]=1 for this single cycle; no irq_ack pulse when spurious.
  - Then go to WAIT_LOW.
- WAIT_LOW:
  - iack=1 and ivec held stable while istb=1.
  - When istb=0, iack and ivec go to 0 on the next cycle and the state returns to IDLE.
- Re-arbitration: every new vector fetch re-evaluates eff from scratch. No request is queued inside the block; peripherals hold their request until they see irq_ack.
- Masking: a source masked after ARMED but before istb does not win. If nothing else is pending, the spurious vector is returned.
- Vector sampling: irq_vec[win] is sampled once, in the istb cycle; later changes to irq_vec do not affect ivec.
- Priority: fixed, with index 0 highest. There is no round-robin.
- Index width: clog2(N), minimum 1 bit.
- Reset mid-transaction: all outputs clear immediately; no irq_ack pulse is emitted after reset.

Decomposition:
Shared package vic_pkg holds:
- the state enum (IDLE, ARMED, ACK, WAIT_LOW);
- the 16-bit vector word width;
- the default SPUR_VEC constant.

Sub-module vic_prio_enc: purely combinational fixed-priority encoder, parameter N, outputs index plus an any flag. It is reused by future DMA arbiters.

Test Plan:
- Reset: irq_req=8'h04, mask=8'hFF, rst_n low → virq=0, iack=0, ivec=0 throughout reset. After release, virq=1 one cycle later.
- Single source: req[2]=1, vec2=16'o000060, istb pulse held 3 cycles → one cycle later iack=1, ivec=16'o000060, irq_ack=8'h04 for exactly 1 cycle, virq=0. iack drops one cycle after istb falls.
- Priority: req=8'h0A (sources 1,3), vec1=16'o000064, vec3=16'o000100 → first fetch returns 16'o000064 and pulses irq_ack[1]. After source 1 drops, the second fetch returns 16'o000100.
- Mask and withdrawal: req[5]=1, virq=1, then mask[5]=0 in the same cycle istb rises → ivec=SPUR_VEC=16'o000000, iack=1, irq_ack=0.
- Spurious from IDLE: no requests, istb=1 → iack=1, ivec=16'o000000, no irq_ack pulse, return to IDLE after istb falls.
- Reset mid-ACK: assert rst_n=0 while iack=1 → iack, ivec and irq_ack clear asynchronously. After release with req still set, the normal ARMED sequence restarts.
